// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB forwarding, load-use detection and ALU operand selection.
// The EX register is a single packed record so hold, bubble and capture are one assignment each.

package id_ex_pkg;
  localparam logic [3:0] EXE_ALU_NOP  = 4'd0;
  localparam logic [3:0] EXE_ALU_ADD  = 4'd1;
  localparam logic [3:0] EXE_ALU_SUB  = 4'd2;
  localparam logic [3:0] EXE_ALU_AND  = 4'd3;
  localparam logic [3:0] EXE_ALU_OR   = 4'd4;
  localparam logic [3:0] EXE_ALU_XOR  = 4'd5;
  localparam logic [3:0] EXE_ALU_NOR  = 4'd6;
  localparam logic [3:0] EXE_ALU_SLT  = 4'd7;
  localparam logic [3:0] EXE_ALU_SLL  = 4'd8;
  localparam logic [3:0] EXE_ALU_SRL  = 4'd9;
  localparam logic [3:0] EXE_ALU_LUI  = 4'd10;
endpackage

module id_ex_stage #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [DW-1:0] id_pc,
  input  logic [AW-1:0] id_rs_addr,
  input  logic [AW-1:0] id_rt_addr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_sa,
  input  logic          id_a_sel,
  input  logic          id_b_sel,
  input  logic [3:0]    id_alu_oper,
  input  logic          id_alu_sign,
  input  logic          id_wb_en,
  input  logic [AW-1:0] id_wb_addr,
  input  logic          id_mem_ren,
  input  logic          id_mem_wen,
  input  logic          mem_wb_en,
  input  logic [AW-1:0] mem_wb_addr,
  input  logic [DW-1:0] mem_data,
  input  logic          wb_wb_en,
  input  logic [AW-1:0] wb_wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          stall_in,
  input  logic          flush,
  output logic          id_stall,
  output logic          exe_valid,
  output logic [DW-1:0] exe_pc,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_oper,
  output logic          alu_sign,
  output logic [DW-1:0] exe_st_data,
  output logic          exe_wb_en,
  output logic [AW-1:0] exe_wb_addr,
  output logic          exe_mem_ren,
  output logic          exe_mem_wen
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [4:0]    sa;
    logic          a_sel;
    logic          b_sel;
    logic [3:0]    oper;
    logic          sign;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic          mem_ren;
    logic          mem_wen;
  } ex_reg_t;

  ex_reg_t       ex_q;
  ex_reg_t       id_fields;
  logic          load_use;
  logic          bubble;
  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;

  // The rt comparison is made even for immediate-form instructions; a spare stall is cheaper than decoding use.
  assign load_use = id_valid & ex_q.valid & ex_q.mem_ren & (ex_q.wb_addr != '0) &
                    ((ex_q.wb_addr == id_rs_addr) | (ex_q.wb_addr == id_rt_addr));
  assign id_stall = stall_in | load_use;
  assign bubble   = flush | load_use | ~id_valid;

  always_comb begin
    id_fields         = '0;
    id_fields.valid   = 1'b1;
    id_fields.pc      = id_pc;
    id_fields.rs_addr = id_rs_addr;
    id_fields.rt_addr = id_rt_addr;
    id_fields.rs_data = id_rs_data;
    id_fields.rt_data = id_rt_data;
    id_fields.imm     = id_imm;
    id_fields.sa      = id_sa;
    id_fields.a_sel   = id_a_sel;
    id_fields.b_sel   = id_b_sel;
    id_fields.oper    = id_alu_oper;
    id_fields.sign    = id_alu_sign;
    id_fields.wb_en   = id_wb_en;
    id_fields.wb_addr = id_wb_addr;
    id_fields.mem_ren = id_mem_ren;
    id_fields.mem_wen = id_mem_wen;
  end

  // NOTE: state is written with <= so every reader in the same edge sees the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (stall_in) begin
      ex_q <= ex_q;
    end else if (bubble) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_fields;
    end
  end

  // MEM is younger than WB, so its result wins; $zero is never forwarded.
  function automatic logic [DW-1:0] forward(input logic [AW-1:0] r, input logic [DW-1:0] rf);
    if (r == '0)
      return '0;
    else if (mem_wb_en && (mem_wb_addr == r))
      return mem_data;
    else if (wb_wb_en && (wb_wb_addr == r))
      return wb_data;
    else
      return rf;
  endfunction

  assign rs_fwd = forward(ex_q.rs_addr, ex_q.rs_data);
  assign rt_fwd = forward(ex_q.rt_addr, ex_q.rt_data);

  assign alu_a       = !ex_q.valid ? '0 :
                       ex_q.a_sel  ? {{(DW-5){1'b0}}, ex_q.sa} : rs_fwd;
  assign alu_b       = !ex_q.valid ? '0 :
                       ex_q.b_sel  ? ex_q.imm : rt_fwd;
  assign alu_oper    = ex_q.valid ? ex_q.oper : 4'd0;
  assign alu_sign    = ex_q.sign;
  assign exe_st_data = ex_q.valid ? rt_fwd : '0;

  assign exe_valid   = ex_q.valid;
  assign exe_pc      = ex_q.pc;
  assign exe_wb_en   = ex_q.wb_en;
  assign exe_wb_addr = ex_q.wb_addr;
  assign exe_mem_ren = ex_q.mem_ren;
  assign exe_mem_wen = ex_q.mem_wen;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized bench for id_ex_stage against an instruction-level reference model.
// The model tracks which instruction sits in EX and derives the expected outputs from that record.

module tb_id_ex_stage;
  import id_ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_sa, id_wb_addr;
  logic        id_a_sel, id_b_sel, id_alu_sign, id_wb_en, id_mem_ren, id_mem_wen;
  logic [3:0]  id_alu_oper;
  logic        mem_wb_en, wb_wb_en, stall_in, flush;
  logic [4:0]  mem_wb_addr, wb_wb_addr;
  logic [31:0] mem_data, wb_data;
  logic        id_stall, exe_valid, alu_sign, exe_wb_en, exe_mem_ren, exe_mem_wen;
  logic [31:0] exe_pc, alu_a, alu_b, exe_st_data;
  logic [3:0]  alu_oper;
  logic [4:0]  exe_wb_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_sa(id_sa), .id_a_sel(id_a_sel),
    .id_b_sel(id_b_sel), .id_alu_oper(id_alu_oper), .id_alu_sign(id_alu_sign),
    .id_wb_en(id_wb_en), .id_wb_addr(id_wb_addr), .id_mem_ren(id_mem_ren),
    .id_mem_wen(id_mem_wen), .mem_wb_en(mem_wb_en), .mem_wb_addr(mem_wb_addr),
    .mem_data(mem_data), .wb_wb_en(wb_wb_en), .wb_wb_addr(wb_wb_addr), .wb_data(wb_data),
    .stall_in(stall_in), .flush(flush), .id_stall(id_stall), .exe_valid(exe_valid),
    .exe_pc(exe_pc), .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper),
    .alu_sign(alu_sign), .exe_st_data(exe_st_data), .exe_wb_en(exe_wb_en),
    .exe_wb_addr(exe_wb_addr), .exe_mem_ren(exe_mem_ren), .exe_mem_wen(exe_mem_wen)
  );

  // The instruction currently occupying EX, or an empty slot.
  typedef struct {
    bit          valid;
    logic [31:0] pc, rs_val, rt_val, imm;
    logic [4:0]  rs, rt, sa, dest;
    bit          use_sa, use_imm, sign, writes, load, store;
    logic [3:0]  op;
  } instr_t;

  instr_t ex;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] value_of(input logic [4:0] r, input logic [31:0] regfile_val);
    if (r == 0) return 32'h0;
    if (mem_wb_en && mem_wb_addr == r) return mem_data;
    if (wb_wb_en && wb_wb_addr == r) return wb_data;
    return regfile_val;
  endfunction

  function automatic bit model_load_use();
    return id_valid && ex.valid && ex.load && ex.dest != 0 &&
           (ex.dest == id_rs_addr || ex.dest == id_rt_addr);
  endfunction

  task automatic compare_all(input string tag);
    logic [31:0] ea, eb, est;
    ea  = !ex.valid ? 32'h0 : ex.use_sa  ? {27'h0, ex.sa} : value_of(ex.rs, ex.rs_val);
    eb  = !ex.valid ? 32'h0 : ex.use_imm ? ex.imm         : value_of(ex.rt, ex.rt_val);
    est = !ex.valid ? 32'h0 : value_of(ex.rt, ex.rt_val);
    check({tag, ".id_stall"},  {31'h0, id_stall},    {31'h0, stall_in | model_load_use()});
    check({tag, ".valid"},     {31'h0, exe_valid},   {31'h0, ex.valid});
    check({tag, ".pc"},        exe_pc,               ex.valid ? ex.pc : 32'h0);
    check({tag, ".alu_a"},     alu_a,                ea);
    check({tag, ".alu_b"},     alu_b,                eb);
    check({tag, ".oper"},      {28'h0, alu_oper},    ex.valid ? {28'h0, ex.op} : 32'h0);
    check({tag, ".sign"},      {31'h0, alu_sign},    {31'h0, ex.valid & ex.sign});
    check({tag, ".st_data"},   exe_st_data,          est);
    check({tag, ".wb_en"},     {31'h0, exe_wb_en},   {31'h0, ex.valid & ex.writes});
    check({tag, ".wb_addr"},   {27'h0, exe_wb_addr}, ex.valid ? {27'h0, ex.dest} : 32'h0);
    check({tag, ".mem_ren"},   {31'h0, exe_mem_ren}, {31'h0, ex.valid & ex.load});
    check({tag, ".mem_wen"},   {31'h0, exe_mem_wen}, {31'h0, ex.valid & ex.store});
  endtask

  // What EX holds after a clock edge, given the inputs present before it.
  task automatic model_edge();
    instr_t nxt;
    if (stall_in) return;
    nxt = '{default: '0};
    if (!(flush || model_load_use() || !id_valid)) begin
      nxt.valid = 1; nxt.pc = id_pc; nxt.rs = id_rs_addr; nxt.rt = id_rt_addr;
      nxt.rs_val = id_rs_data; nxt.rt_val = id_rt_data; nxt.imm = id_imm; nxt.sa = id_sa;
      nxt.use_sa = id_a_sel; nxt.use_imm = id_b_sel; nxt.op = id_alu_oper;
      nxt.sign = id_alu_sign; nxt.writes = id_wb_en; nxt.dest = id_wb_addr;
      nxt.load = id_mem_ren; nxt.store = id_mem_wen;
    end
    ex = nxt;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(input string tag);
    #1 compare_all(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic wen, input logic [4:0] dest, input logic ren);
    id_valid = 1; id_pc = pc; id_rs_addr = rs; id_rt_addr = rt;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = 32'h0; id_sa = 5'd0;
    id_a_sel = 0; id_b_sel = 0; id_alu_oper = EXE_ALU_ADD; id_alu_sign = 1;
    id_wb_en = wen; id_wb_addr = dest; id_mem_ren = ren; id_mem_wen = 0;
  endtask

  task automatic clear_fwd();
    mem_wb_en = 0; mem_wb_addr = 0; mem_data = 0;
    wb_wb_en = 0; wb_wb_addr = 0; wb_data = 0;
  endtask

  initial begin
    ex = '{default: '0};
    rst_n = 0; stall_in = 0; flush = 0;
    set_id(32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 0);
    id_valid = 0;
    clear_fwd();
    repeat (2) @(negedge clk);
    compare_all("reset");
    check("reset.alu_oper", {28'h0, alu_oper}, 32'h0);

    // First edge after reset release captures ID.
    rst_n = 1;
    set_id(32'h40, 5'd3, 5'd4, 32'h333, 32'h444, 1, 5'd7, 0);
    step("capture");
    check("capture.valid", {31'h0, exe_valid}, 32'h1);

    // MEM has priority over WB, then WB alone.
    id_valid = 0;
    mem_wb_en = 1; mem_wb_addr = 3; mem_data = 32'h11;
    wb_wb_en = 1;  wb_wb_addr = 3;  wb_data = 32'h22;
    #1 check("fwd.mem_prio", alu_a, 32'h11);
    mem_wb_addr = 9;
    #1 check("fwd.wb", alu_a, 32'h22);
    compare_all("fwd");

    // Asynchronous reset while EX holds a real instruction and a stall is active.
    stall_in = 1;
    @(posedge clk); model_edge();
    #2 rst_n = 0;
    #1 ex = '{default: '0};
    check("async.valid", {31'h0, exe_valid}, 32'h0);
    check("async.wb_en", {31'h0, exe_wb_en}, 32'h0);
    check("async.alu_a", alu_a, 32'h0);
    @(negedge clk);
    rst_n = 1; stall_in = 0; clear_fwd();

    // $zero is never forwarded.
    set_id(32'h50, 5'd0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 0);
    step("zero_cap");
    id_valid = 0;
    mem_wb_en = 1; mem_wb_addr = 0; mem_data = 32'hFFFF;
    #1 check("zero.alu_a", alu_a, 32'h0);
    step("zero");
    clear_fwd();

    // Load-use: lw $5 then add using rt=$5 costs one bubble.
    set_id(32'h100, 5'd1, 5'd0, 32'h0, 32'h0, 1, 5'd5, 1);
    step("lw");
    set_id(32'h104, 5'd1, 5'd5, 32'h10, 32'hDEAD, 1, 5'd6, 0);
    #1 check("lu.stall", {31'h0, id_stall}, 32'h1);
    step("lu");
    check("lu.bubble", {31'h0, exe_valid}, 32'h0);
    mem_wb_en = 1; mem_wb_addr = 5; mem_data = 32'hABC;
    step("lu_wait");
    clear_fwd();
    wb_wb_en = 1; wb_wb_addr = 5; wb_data = 32'hABC;
    id_valid = 0;
    #1 check("lu.add_b", alu_b, 32'hABC);
    check("lu.add_pc", exe_pc, 32'h104);
    step("lu_add");
    clear_fwd();

    // stall_in holds EX for three cycles, ignoring flush; then flush squashes.
    set_id(32'h200, 5'd2, 5'd3, 32'h1, 32'h2, 0, 5'd0, 0);
    id_mem_wen = 1;
    step("st_cap");
    set_id(32'h204, 5'd4, 5'd4, 32'h9, 32'h9, 1, 5'd4, 0);
    stall_in = 1;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      step("hold");
      check("hold.pc", exe_pc, 32'h200);
    end
    stall_in = 0; flush = 1;
    step("flush");
    check("flush.valid", {31'h0, exe_valid}, 32'h0);
    check("flush.mem_wen", {31'h0, exe_mem_wen}, 32'h0);
    flush = 0;

    // Flush coinciding with load-use still raises id_stall and bubbles.
    set_id(32'h300, 5'd0, 5'd0, 32'h0, 32'h0, 1, 5'd5, 1);
    step("lw2");
    set_id(32'h304, 5'd5, 5'd1, 32'h0, 32'h0, 1, 5'd2, 0);
    flush = 1;
    #1 check("fl_lu.stall", {31'h0, id_stall}, 32'h1);
    step("fl_lu");
    check("fl_lu.valid", {31'h0, exe_valid}, 32'h0);
    flush = 0;

    // Operand muxing with sa and imm.
    set_id(32'h400, 5'd1, 5'd2, 32'h5, 32'h6, 1, 5'd3, 0);
    id_a_sel = 1; id_sa = 5'd4; id_b_sel = 1; id_imm = 32'hFFFF_FFF0;
    step("mux_cap");
    id_valid = 0;
    #1 check("mux.alu_a", alu_a, 32'h4);
    check("mux.alu_b", alu_b, 32'hFFFF_FFF0);
    check("mux.oper", {28'h0, alu_oper}, {28'h0, EXE_ALU_ADD});
    step("mux");

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      id_valid    = ($urandom_range(0, 9) < 8);
      id_pc       = $urandom;
      id_rs_addr  = 5'($urandom_range(0, 3));
      id_rt_addr  = 5'($urandom_range(0, 3));
      id_rs_data  = $urandom;
      id_rt_data  = $urandom;
      id_imm      = $urandom;
      id_sa       = 5'($urandom);
      id_a_sel    = 1'($urandom);
      id_b_sel    = 1'($urandom);
      id_alu_oper = 4'($urandom);
      id_alu_sign = 1'($urandom);
      id_wb_en    = 1'($urandom);
      id_wb_addr  = 5'($urandom_range(0, 3));
      id_mem_ren  = ($urandom_range(0, 9) < 3);
      id_mem_wen  = !id_mem_ren && ($urandom_range(0, 9) < 2);
      mem_wb_en   = 1'($urandom);
      mem_wb_addr = 5'($urandom_range(0, 3));
      mem_data    = $urandom;
      wb_wb_en    = 1'($urandom);
      wb_wb_addr  = 5'($urandom_range(0, 3));
      wb_data     = $urandom;
      stall_in    = ($urandom_range(0, 99) < 15);
      flush       = ($urandom_range(0, 99) < 10);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and EX-side operand selector for the 5-stage MIPS core.
- Latches decoded operands and control from ID, and resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards and reports them upstream as a stall.
- Drives `a`, `b`, `oper` and `sign` of the ALU combinationally from the registered stage contents.

Parameters:
- AW, 5, register-file address width
- DW, 32, datapath width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DW  PC of the ID instruction
- id_rs_addr, id_rt_addr  in  AW  source register numbers
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  DW  immediate, already sign- or zero-extended by the decoder
- id_sa  in  5  shift amount
- id_a_sel  in  1  0: forwarded rs; 1: {27'b0, sa}
- id_b_sel  in  1  0: forwarded rt; 1: imm
- id_alu_oper  in  4  ALU operation code (EXE_ALU_*)
- id_alu_sign  in  1  signed compare / arithmetic shift
- id_wb_en  in  1  instruction writes the register file
- id_wb_addr  in  AW  destination register
- id_mem_ren, id_mem_wen  in  1  load / store
- mem_wb_en  in  1  MEM-stage instruction writes a register
- mem_wb_addr  in  AW  MEM-stage destination
- mem_data  in  DW  MEM-stage ALU result
- wb_wb_en  in  1  WB-stage write enable
- wb_wb_addr  in  AW  WB-stage destination
- wb_data  in  DW  WB-stage write data
- stall_in  in  1  downstream stall: hold the EX register
- flush  in  1  branch/jump squash of the ID instruction
- id_stall  out  1  ID/IF must hold this cycle
- exe_valid  out  1  EX holds a real instruction
- exe_pc  out  DW  EX PC
- alu_a, alu_b  out  DW  ALU operands
- alu_oper  out  4  ALU operation code
- alu_sign  out  1  ALU sign control
- exe_st_data  out  DW  forwarded rt value (store data)
- exe_wb_en  out  1  EX write enable
- exe_wb_addr  out  AW  EX destination register
- exe_mem_ren, exe_mem_wen  out  1  EX load / store

Behaviour:
- Reset (rst_n=0, asynchronous)
  - All EX registers clear to 0, including exe_valid, controls, data and addresses.
  - Outputs therefore read: alu_oper=0, alu_a=alu_b=0, id_stall=0.
- Load-use hazard, combinational
  - load_use = id_valid & exe_valid & exe_mem_ren & (exe_wb_addr!=0) & (exe_wb_addr==id_rs_addr | exe_wb_addr==id_rt_addr).
  - The rt match counts even when id_b_sel=1. This is conservative by design.
- id_stall = stall_in | load_use.
- Register update, on each rising edge, in priority order:
  1. stall_in=1: hold all EX registers. flush is ignored; the upstream stage retains the branch.
  2. flush=1 or load_use=1 or id_valid=0: load a bubble. exe_valid, exe_wb_en, exe_mem_ren and exe_mem_wen are 0; data fields are don't-care but are cleared to 0.
  3. Otherwise: capture all id_* fields; exe_valid=1.
- Forwarding, combinational on registered rs/rt. For each source register r:
  - r==0 → 0.
  - Else mem_wb_en & mem_wb_addr==r → mem_data. MEM has priority.
  - Else wb_wb_en & wb_wb_addr==r → wb_data.
  - Else the latched register-file data.
  - A load in MEM never appears as a MEM forward, because the load-use bubble guarantees that.
- Operand selection
  - alu_a = a_sel ? {27'b0, sa} : rs_fwd.
  - alu_b = b_sel ? imm : rt_fwd.
  - exe_st_data = rt_fwd.
- Bubble outputs: alu_oper=0 and alu operands are 0.
- Latency:
  - one cycle from ID to EX;
  - forwarding adds no cycles;
  - a load-use costs exactly one bubble.
- Simultaneous flush and load_use: a bubble, and id_stall still asserts for that cycle. The upstream stage applies flush priority.
- A reset asserted mid-stall clears the stage immediately, without waiting for a clock edge.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with exe_valid=1 → exe_valid=0, exe_wb_en=0, alu_a=0 with no clock edge; release rst_n → first edge captures ID.
- MEM forward priority: EX rs=$3; mem_wb_en=1, mem_wb_addr=3, mem_data=0x11; wb_wb_en=1, wb_wb_addr=3, wb_data=0x22 → alu_a=0x11. Drop the MEM match → alu_a=0x22.
- $zero guard: rs=0 with mem_wb_addr=0, mem_wb_en=1, mem_data=0xFFFF → alu_a=0.
- Load-use: EX holds lw into $5; ID holds add using rt=$5 → id_stall=1 for one cycle. Next edge: exe_valid=0. The following edge: add enters, with $5 taken from the WB or MEM forward.
- stall_in and flush: stall_in=1 for 3 cycles → EX registers unchanged, including exe_pc. Then flush=1 with stall_in=0 → next exe_valid=0, exe_mem_wen=0.
- Operand muxing: a_sel=1, sa=4, b_sel=1, imm=0xFFFF_FFF0, oper=EXE_ALU_ADD → alu_a=4, alu_b=0xFFFF_FFF0, alu_oper=EXE_ALU_ADD.
